arb_rr_ctrl: RTL and testbench

- Sequential arbiter that shares one resource among N requesters using a priority-encoder pick.
- Supports fixed priority (lowest index wins) and round-robin modes.
- A grant is held until the grantee releases or a hold timeout expires.
- Sits in front of any shared datapath/bus port; the downstream mux is steered by gnt_idx.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 35 +++
 rtl/arb_rr_ctrl.sv | 94 +++++++++
 tb/tb_arb_rr_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
// Imported by the picker and the arbiter control block.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int N_DEF        = 8;
    localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// Masked priority encoder: lowest request at or above ptr in
// round-robin mode, falling back to the lowest request overall.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = $clog2(N_DEF)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] below;
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    assign below  = (ONE << ptr) - ONE;
    assign masked = (mode == MODE_RR) ? (req & ~below) : req;
    assign pool   = (|masked) ? masked : req;
    assign any    = |req;

    // Lowest set bit of the chosen pool wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pool[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/arb_rr_ctrl.sv
// Arbiter control: IDLE/BUSY FSM, hold timer, round-robin pointer
// and registered grant outputs steering the shared resource.
module arb_rr_ctrl
    import arb_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    input  logic             mode,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [N-1:0]     ONE     = N'(1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] rr_ptr;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             withdrawn;
    logic             expired;
    logic             release_now;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .mode (mode),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign withdrawn   = ~req[gnt_idx];
    assign expired     = (hold_cnt == HOLD_LIM);
    assign release_now = done | withdrawn | expired;

    // Arbitration FSM with registered grant outputs and hold timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            rr_ptr    <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= BUSY;
                        gnt       <= ONE << pick_idx;
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        if (mode == MODE_RR) begin
                            rr_ptr <= pick_idx + IDX_W'(1);
                        end
                    end
                end
                BUSY: begin
                    if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                    if (release_now) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= expired & ~done & ~withdrawn;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_rr_ctrl.sv
// Directed self-checking bench for the round-robin arbiter.
// Inputs change 1 time unit after each rising edge.
module tb_arb_rr_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       mode;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    arb_rr_ctrl #(
        .N        (8),
        .IDX_W    (3),
        .MAX_HOLD (16),
        .CNT_W    (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        done  = 1'b0;
        mode  = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = '0;
        done  = 1'b0;
        mode  = 1'b0;
        rst_n = 1'b0;
        step();
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'd0) begin
            failures++;
            $display("FAIL reset_state: got gnt=%h idx=%0d v=%b to=%b want all 0",
                     gnt, gnt_idx, gnt_valid, timeout);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got valid=%b want 0", gnt_valid);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0;
        req  = 8'b1010_0100;
        step();
        checks++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL fixed_grant: got gnt=%h idx=%0d v=%b want 04/2/1",
                     gnt, gnt_idx, gnt_valid);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL fixed_gap: got gnt=%h v=%b want 00/0", gnt, gnt_valid);
        end
        step();
        checks++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
            failures++;
            $display("FAIL fixed_regrant: got gnt=%h idx=%0d want 04/2", gnt, gnt_idx);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_rr();
        logic [2:0] exp_idx;
        logic [7:0] exp_gnt;
        do_reset();
        mode = 1'b1;
        req  = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_idx = 3'(k % 8);
            exp_gnt = 8'(1) << exp_idx;
            step();
            checks++;
            if (gnt !== exp_gnt || gnt_idx !== exp_idx) begin
                failures++;
                $display("FAIL rr_seq[%0d]: got gnt=%h idx=%0d want %h/%0d",
                         k, gnt, gnt_idx, exp_gnt, exp_idx);
            end
            done = 1'b1;
            step();
            done = 1'b0;
            checks++;
            if (gnt !== 8'h00) begin
                failures++;
                $display("FAIL rr_gap[%0d]: got gnt=%h want 00", k, gnt);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_rr_wrap();
        do_reset();
        mode = 1'b1;
        req  = 8'b0010_0000;
        step();
        checks++;
        if (gnt_idx !== 3'd5) begin
            failures++;
            $display("FAIL wrap_first: got idx=%0d want 5", gnt_idx);
        end
        req = '0;
        step();
        req = 8'b0000_0011;
        step();
        checks++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL wrap_grant: got gnt=%h idx=%0d want 01/0", gnt, gnt_idx);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        checks++;
        if (gnt !== 8'h02 || gnt_idx !== 3'd1) begin
            failures++;
            $display("FAIL wrap_ptr1: got gnt=%h idx=%0d want 02/1", gnt, gnt_idx);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        mode = 1'b0;
        req  = 8'h10;
        step();
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (gnt !== 8'h10 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle[%0d]: got gnt=%h to=%b want 10/0",
                         c, gnt, timeout);
            end
            if (c < 16) step();
        end
        step();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b1 || gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: got gnt=%h to=%b v=%b want 00/1/0",
                     gnt, timeout, gnt_valid);
        end
        step();
        checks++;
        if (timeout !== 1'b0 || gnt !== 8'h10) begin
            failures++;
            $display("FAIL timeout_one_cycle: got to=%b gnt=%h want 0/10",
                     timeout, gnt);
        end
        for (int c = 2; c <= 16; c++) step();
        checks++;
        if (gnt !== 8'h10) begin
            failures++;
            $display("FAIL hold_cycle16: got gnt=%h want 10", gnt);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL done_beats_timeout: got gnt=%h to=%b want 00/0",
                     gnt, timeout);
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_withdraw();
        do_reset();
        mode = 1'b0;
        req  = 8'h02;
        step();
        checks++;
        if (gnt_idx !== 3'd1 || gnt !== 8'h02) begin
            failures++;
            $display("FAIL withdraw_grant: got gnt=%h idx=%0d want 02/1", gnt, gnt_idx);
        end
        req = '0;
        step();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_release: got gnt=%h v=%b to=%b want 00/0/0",
                     gnt, gnt_valid, timeout);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'd0) begin
            failures++;
            $display("FAIL done_idle: got gnt=%h idx=%0d v=%b to=%b want all 0",
                     gnt, gnt_idx, gnt_valid, timeout);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        mode = 1'b0;
        req  = 8'h08;
        step();
        checks++;
        if (gnt_idx !== 3'd3) begin
            failures++;
            $display("FAIL pre_reset_grant: got idx=%0d want 3", gnt_idx);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset: got gnt=%h idx=%0d v=%b to=%b want all 0",
                     gnt, gnt_idx, gnt_valid, timeout);
        end
        req = '0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        mode  = 1'b0;
        test_reset();
        test_fixed();
        test_rr();
        test_rr_wrap();
        test_timeout();
        test_withdraw();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
